// File: rtl/sprite_cmd_queue.sv
// sprite_cmd_queue: frame-synchronous command FIFO feeding the shared sprite
// command bus. Buffer-toggle commands (action == 4'hF) are held until vertical
// blanking, and at most one toggle is released per blanking interval.
// Optional feature macro: SPRITE_CMD_QUEUE_STATS_EN builds a saturating
// dropped-write counter; without it dropped_count is tied to zero.
module sprite_cmd_queue #(
  parameter int DEPTH    = 16,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic [6:0]  level,
  output logic        overflow,
  output logic [15:0] dropped_count
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [6:0]      DEPTH_L    = 7'(DEPTH);
  localparam logic [9:0]      V_ACTIVE_L = 10'(V_ACTIVE);

  typedef enum logic {RUN, HOLD} state_t;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   head;
  logic          empty;
  logic          full;
  logic          is_toggle;
  logic          vblank;
  logic          release_ok;
  logic          swap_done;
  logic          offer;
  logic          push;
  logic          drop;
  logic          pop;
  state_t        state;
  state_t        state_next;

  assign head       = mem[rd_ptr];
  assign empty      = (level == 7'd0);
  assign full       = (level == DEPTH_L);
  assign is_toggle  = (head[20:17] == 4'hF);
  assign vblank     = (vcount >= V_ACTIVE_L);
  assign release_ok = vblank & ~swap_done;
  assign offer      = chipselect & write;
  // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
  assign push       = offer & (~full | pop);
  assign drop       = offer & ~push;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  // Next-state logic: park in HOLD while a toggle waits for a fresh blanking interval.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      RUN:  if (!empty && is_toggle && !release_ok) state_next = HOLD;
      HOLD: if (release_ok)                         state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Output logic: decide whether the head word is popped this cycle.
  always_comb begin
    pop = 1'b0;
    case (state)
      RUN:  pop = !empty && (!is_toggle || release_ok);
      HOLD: pop = release_ok;
      default: pop = 1'b0;
    endcase
  end

  // Storage array write port.
  // NOTE: the storage array is deliberately not reset; the pointers and level
  // define which entries are valid, so clearing the RAM would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= writedata;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 7'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 7'd1;
        2'b01:   level <= level - 7'd1;
        default: level <= level;
      endcase
    end
  end

  // Registered command bus: popped word for one cycle, otherwise idle zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cmd_out <= 32'h0;
    else if (pop) cmd_out <= head;
    else          cmd_out <= 32'h0;
  end

  // One-toggle-per-blanking guard: armed by a toggle pop, cleared once blanking ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               swap_done <= 1'b0;
    else if (!vblank)         swap_done <= 1'b0;
    else if (pop && is_toggle) swap_done <= 1'b1;
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef SPRITE_CMD_QUEUE_STATS_EN
  // Saturating count of dropped host writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               dropped_count <= 16'h0;
    else if (drop && dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'h1;
  end
`else
  assign dropped_count = 16'h0;
`endif

endmodule

// File: tb/tb_sprite_cmd_queue.sv
// tb_sprite_cmd_queue: directed vector table for streaming, toggle hold and
// blanking release, plus hand sequences for full/overflow and async reset.
module tb_sprite_cmd_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;
  logic [6:0]  level;
  logic        overflow;
  logic [15:0] dropped_count;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] TOG  = 32'h241E2000;
  localparam logic [31:0] TOG2 = 32'h241E2001;

`ifdef SPRITE_CMD_QUEUE_STATS_EN
  localparam logic [15:0] EXP_DROPS = 16'd4;
`else
  localparam logic [15:0] EXP_DROPS = 16'd0;
`endif

  typedef struct {
    logic        wr;
    logic [31:0] wdata;
    logic [9:0]  vc;
    logic [31:0] exp_cmd;
    logic [6:0]  exp_level;
    logic        exp_ovf;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  sprite_cmd_queue #(.DEPTH(16), .V_ACTIVE(480)) dut (
    .clk           (clk),
    .reset         (reset),
    .chipselect    (chipselect),
    .write         (write),
    .writedata     (writedata),
    .vcount        (vcount),
    .cmd_out       (cmd_out),
    .level         (level),
    .overflow      (overflow),
    .dropped_count (dropped_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic cycle(input logic wr, input logic [31:0] data, input logic [9:0] vc);
    @(negedge clk);
    chipselect = wr;
    write      = wr;
    writedata  = data;
    vcount     = vc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = 32'h0;
    vcount     = 10'd100;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Streaming, toggle hold until vblank, one toggle per blanking interval.
    vecs[0]  = '{1'b1, 32'h24020005, 10'd100, 32'h0,        7'd1, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,        10'd100, 32'h24020005, 7'd0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,        10'd100, 32'h0,        7'd0, 1'b0};
    vecs[3]  = '{1'b1, TOG,          10'd100, 32'h0,        7'd1, 1'b0};
    vecs[4]  = '{1'b1, 32'h24020010, 10'd100, 32'h0,        7'd2, 1'b0};
    vecs[5]  = '{1'b1, 32'h24020020, 10'd100, 32'h0,        7'd3, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,        10'd100, 32'h0,        7'd3, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,        10'd479, 32'h0,        7'd3, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,        10'd480, TOG,          7'd2, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,        10'd481, 32'h24020010, 7'd1, 1'b0};
    vecs[10] = '{1'b0, 32'h0,        10'd482, 32'h24020020, 7'd0, 1'b0};
    vecs[11] = '{1'b0, 32'h0,        10'd482, 32'h0,        7'd0, 1'b0};
    vecs[12] = '{1'b0, 32'h0,        10'd0,   32'h0,        7'd0, 1'b0};
    vecs[13] = '{1'b1, TOG,          10'd490, 32'h0,        7'd1, 1'b0};
    vecs[14] = '{1'b1, TOG2,         10'd490, TOG,          7'd1, 1'b0};
    vecs[15] = '{1'b0, 32'h0,        10'd490, 32'h0,        7'd1, 1'b0};
    vecs[16] = '{1'b0, 32'h0,        10'd500, 32'h0,        7'd1, 1'b0};
    vecs[17] = '{1'b0, 32'h0,        10'd0,   32'h0,        7'd1, 1'b0};
    vecs[18] = '{1'b0, 32'h0,        10'd479, 32'h0,        7'd1, 1'b0};
    vecs[19] = '{1'b0, 32'h0,        10'd480, TOG2,         7'd0, 1'b0};
    vecs[20] = '{1'b0, 32'h0,        10'd480, 32'h0,        7'd0, 1'b0};

    reset      = 1'b0;
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = 32'h0;
    vcount     = 10'd100;
    #12;
    check("reset_cmd",   cmd_out, 32'h0);
    check("reset_level", {25'h0, level}, 32'h0);
    check("reset_ovf",   {31'h0, overflow}, 32'h0);
    check("reset_drops", {16'h0, dropped_count}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      cycle(vecs[i].wr, vecs[i].wdata, vecs[i].vc);
      check($sformatf("vec%0d_cmd", i),   cmd_out, vecs[i].exp_cmd);
      check($sformatf("vec%0d_level", i), {25'h0, level}, {25'h0, vecs[i].exp_level});
      check($sformatf("vec%0d_ovf", i),   {31'h0, overflow}, {31'h0, vecs[i].exp_ovf});
    end

    // Full FIFO draining: a write on the pop cycle is accepted.
    do_reset();
    cycle(1'b1, TOG, 10'd100);
    for (int k = 1; k < 16; k++) cycle(1'b1, 32'h24020100 + k, 10'd100);
    check("full_level", {25'h0, level}, 32'd16);
    check("full_ovf",   {31'h0, overflow}, 32'h0);
    cycle(1'b1, 32'h24020200, 10'd480);
    check("drain0_cmd",   cmd_out, TOG);
    check("drain0_level", {25'h0, level}, 32'd16);
    check("drain0_ovf",   {31'h0, overflow}, 32'h0);
    cycle(1'b1, 32'h24020201, 10'd480);
    check("drain1_cmd",   cmd_out, 32'h24020101);
    check("drain1_level", {25'h0, level}, 32'd16);
    check("drain1_ovf",   {31'h0, overflow}, 32'h0);

    // Overflow: 20 back-to-back writes while held.
    do_reset();
    cycle(1'b1, TOG, 10'd100);
    for (int k = 1; k < 20; k++) begin
      cycle(1'b1, 32'h24020300 + k, 10'd100);
      if (k == 15) begin
        check("ovf16_level", {25'h0, level}, 32'd16);
        check("ovf16_ovf",   {31'h0, overflow}, 32'h0);
      end
    end
    check("ovf_level", {25'h0, level}, 32'd16);
    check("ovf_flag",  {31'h0, overflow}, 32'h1);
    check("ovf_drops", {16'h0, dropped_count}, {16'h0, EXP_DROPS});
    cycle(1'b0, 32'h0, 10'd480);
    check("rel_cmd",   cmd_out, TOG);
    check("rel_level", {25'h0, level}, 32'd15);
    cycle(1'b0, 32'h0, 10'd480);
    check("burst_cmd",   cmd_out, 32'h24020301);
    check("burst_level", {25'h0, level}, 32'd14);

    // Asynchronous reset mid-burst: outputs clear before any clock edge.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("areset_cmd",   cmd_out, 32'h0);
    check("areset_level", {25'h0, level}, 32'h0);
    check("areset_ovf",   {31'h0, overflow}, 32'h0);
    check("areset_drops", {16'h0, dropped_count}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 32'h0, 10'd480);
      check($sformatf("post_reset%0d_cmd", k),   cmd_out, 32'h0);
      check($sformatf("post_reset%0d_level", k), {25'h0, level}, 32'h0);
    end
    cycle(1'b1, 32'h24020005, 10'd100);
    cycle(1'b0, 32'h0, 10'd100);
    check("post_reset_stream", cmd_out, 32'h24020005);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_cmd_queue.md
# sprite_cmd_queue

Frame-synchronous command queue between the host write port and the sprite display blocks. It buffers 32-bit sprite command words written by the host and replays them one per cycle onto a shared command bus that every sprite display decodes. Buffer-toggle commands are held until vertical blanking, so ping/pong swaps never tear mid-frame.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 4..64.
- `V_ACTIVE`, 480: first `vcount` value that counts as vertical blanking.

Ports:
- `clk`  in  1  single system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset; released synchronously by the board reset logic.
- `chipselect`  in  1  host port select.
- `write`  in  1  host write strobe; a word is offered when `chipselect & write`.
- `writedata`  in  32  host command word; same field layout as the sprite bus (component [31:26], child [25:21], action [20:17], type [16:14], toggle [13], data [12:0]).
- `vcount`  in  10  current scan line from the VGA timing block.
- `cmd_out`  out  32  registered command bus to all sprite displays; `32'h0` when idle (component 0 is reserved, matched by no sprite).
- `level`  out  7  current FIFO occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was dropped because the FIFO was full.
- `dropped_count`  out  16  dropped-write counter (see Configuration).

## Operation
- Enqueue: offered word is stored when `level < DEPTH`, or when `level == DEPTH` and a pop occurs in the same cycle. Otherwise it is dropped and `overflow` sets; `overflow` clears only on reset.
- Toggle command: head word with action == 4'hF.
- `vblank` = (`vcount >= V_ACTIVE`). `swap_done` flag: set when a toggle pops; cleared on the first cycle `vblank` is 0.
- FSM, two states:
  - RUN: if FIFO empty, `cmd_out` <= 0. If head is not a toggle, pop it to `cmd_out`. If head is a toggle and `vblank & ~swap_done`, pop it and set `swap_done`; otherwise go to HOLD and drive `cmd_out` <= 0.
  - HOLD: `cmd_out` <= 0, no pops. Return to RUN in the cycle when `vblank & ~swap_done`; the toggle pops in that same cycle.
- At most one toggle per blanking interval. Words queued behind a held toggle stay queued, so command ordering is strictly preserved.
- Each popped word is presented on `cmd_out` for exactly one cycle.

## Timing
- Reset (asserted low): `cmd_out` = 0, `level` = 0, `overflow` = 0, `dropped_count` = 0, `swap_done` = 0, FSM = RUN, FIFO pointers = 0. Reset mid-burst discards all queued words.
- Latency: a word offered at edge N onto an empty, non-held FIFO is stored at N and appears on `cmd_out` after edge N+1, for one cycle.
- Throughput: one pop per cycle. Back-to-back writes stream at one word per cycle with constant 1-cycle latency.
- `level` updates on the same edge as the push or pop; a simultaneous push and pop leaves it unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. `level` is a separate counter with range 0..DEPTH.
- A toggle reaching the head during vblank with `swap_done` = 0 pops without entering HOLD.

## Configuration
- `SPRITE_CMD_QUEUE_STATS_EN` defined: `dropped_count` increments on each dropped write and saturates at 16'hFFFF.
- Not defined: `dropped_count` is tied to 0 and no counter logic is built; `overflow` still works.

## Test plan
- Reset, then write 32'h24020005 with `vcount` = 100 -> `cmd_out` = 32'h24020005 for one cycle, one cycle after the write edge; `level` returns to 0.
- Write toggle 32'h241E2000 at `vcount` = 100, then two position words -> `cmd_out` stays 0 and `level` = 3 until `vcount` = 480. Then toggle, word 2, and word 3 appear on consecutive cycles.
- Two toggles queued during vblank -> first pops; second is held until `vcount` leaves blanking and re-enters at 480 of the next frame.
- Write 20 words in consecutive cycles with DEPTH = 16 while held in HOLD -> `level` = 16, `overflow` = 1, `dropped_count` = 4 with the macro defined (0 without).
- With FIFO full and draining, write on the pop cycle -> write accepted, `level` stays 16, `overflow` stays 0.
- Assert `reset` low while 5 words are queued -> all outputs 0 immediately (asynchronous); no queued word appears after release.
